// File: rtl/fir_mc_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, width helpers and saturation limits for the serial multi-channel FIR.
package fir_mc_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_e;

  // Two cycles to empty the product and accumulator registers, one to load the output register.
  localparam int DRAIN_CYC = 3;

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic longint sat_max(input int data_w);
    return (64'sd1 <<< (data_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(64'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/fir_mac_core.sv
`timescale 1ns/1ps
// Registered multiplier feeding a clearable accumulator, with combinational round-half-up and saturation.
module fir_mac_core
  import fir_mc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 38,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] h_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     sat_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND_C = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) <<< RND_SH) : '0;
  localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'(sat_max(DATA_W));
  localparam logic signed [ACC_W:0] Y_MIN = (ACC_W+1)'(sat_min(DATA_W));

  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else if (clr_i) begin
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_vld_q <= en_i;
      if (en_i) prod_q <= PROD_W'(x_i) * PROD_W'(h_i);
      if (prod_vld_q) acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  // One guard bit above the accumulator so the rounding constant cannot wrap.
  always_comb begin
    rnd   = (ACC_W+1)'(acc_q) + RND_C;
    shf   = rnd >>> OUT_SHIFT;
    y_o   = DATA_W'(shf);
    sat_o = 1'b0;
    if (shf > Y_MAX) begin
      y_o   = DATA_W'(Y_MAX);
      sat_o = 1'b1;
    end else if (shf < Y_MIN) begin
      y_o   = DATA_W'(Y_MIN);
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mc_serial.sv
`timescale 1ns/1ps
// Time-multiplexed multi-channel FIR: one MAC per tap over per-channel circular histories and a writable coefficient RAM.
module fir_mc_serial
  import fir_mc_pkg::*;
#(
  parameter int TAP_LEN   = 63,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int OUT_SHIFT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ch_w(NUM_CH)-1:0]      in_ch,
  input  logic signed [DATA_W-1:0]     in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ch_w(NUM_CH)-1:0]      out_ch,
  output logic signed [DATA_W-1:0]     out_data,
  output logic                         out_sat,
  input  logic                         coef_we,
  input  logic [$clog2(TAP_LEN)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]     coef_wdata,
  output logic                         busy
);

  localparam int CH_W   = ch_w(NUM_CH);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAP_LEN);
  localparam int IDX_W  = $clog2(TAP_LEN);
  localparam int HIST_N = NUM_CH * TAP_LEN;
  localparam int HA_W   = $clog2(HIST_N);
  localparam int CNT_W  = $clog2(HIST_N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(HIST_N - 1);
  localparam logic [CNT_W-1:0] TAP_LAST   = CNT_W'(TAP_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TAP_LEN - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic [CH_W-1:0]          ch_q, ch_d, ch_sel;
  logic [IDX_W-1:0]         wptr_q [NUM_CH];
  logic                     wptr_adv, acc_clr, issue, issue_vld_q, out_load;
  logic                     hist_we;
  logic [HA_W-1:0]          hist_waddr, hist_raddr;
  logic signed [DATA_W-1:0] hist_wdat, hist_rd_q;
  logic                     coef_wen;
  logic [IDX_W-1:0]         coef_waddr;
  logic signed [COEF_W-1:0] coef_wdat, coef_rd_q;
  logic signed [DATA_W-1:0] hist_mem [HIST_N];
  logic signed [COEF_W-1:0] coef_mem [TAP_LEN];
  logic signed [DATA_W-1:0] y;
  logic                     y_sat;
  logic signed [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]          out_ch_q;
  logic                     out_sat_q;

  function automatic logic [HA_W-1:0] hist_addr(input logic [CH_W-1:0] c, input logic [IDX_W-1:0] i);
    return HA_W'(int'(c) * TAP_LEN + int'(i));
  endfunction

  // Out-of-range channel numbers fold onto the last channel.
  assign ch_sel     = (int'(in_ch) >= NUM_CH) ? CH_W'(NUM_CH - 1) : in_ch;
  assign hist_raddr = hist_addr(ch_q, rd_idx_q);
  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_OUT);
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_sat    = out_sat_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    ch_d       = ch_q;
    acc_clr    = 1'b0;
    issue      = 1'b0;
    out_load   = 1'b0;
    wptr_adv   = 1'b0;
    hist_we    = 1'b0;
    hist_waddr = '0;
    hist_wdat  = '0;
    coef_wen   = 1'b0;
    coef_waddr = '0;
    coef_wdat  = '0;
    case (state_q)
      ST_CLEAR: begin
        hist_we    = 1'b1;
        hist_waddr = HA_W'(cnt_q);
        coef_wen   = (cnt_q <= TAP_LAST);
        coef_waddr = IDX_W'(cnt_q);
        cnt_d      = cnt_q + CNT_ONE;
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        coef_wen   = coef_we && (coef_addr <= IDX_LAST);
        coef_waddr = coef_addr;
        coef_wdat  = coef_wdata;
        if (in_valid) begin
          hist_we    = 1'b1;
          hist_waddr = hist_addr(ch_sel, wptr_q[ch_sel]);
          hist_wdat  = in_data;
          ch_d       = ch_sel;
          rd_idx_d   = wptr_q[ch_sel];
          cnt_d      = '0;
          acc_clr    = 1'b1;
          state_d    = ST_MAC;
        end
      end
      ST_MAC: begin
        // Walk backwards from the newest sample: tap k reads x[n-k].
        issue    = 1'b1;
        rd_idx_d = (rd_idx_q == '0) ? IDX_LAST : rd_idx_q - IDX_ONE;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == TAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d    = '0;
          out_load = 1'b1;
          wptr_adv = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      ch_q        <= '0;
      issue_vld_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_idx_q    <= rd_idx_d;
      ch_q        <= ch_d;
      issue_vld_q <= issue;
      if (out_load) begin
        out_data_q <= y;
        out_ch_q   <= ch_q;
        out_sat_q  <= y_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) wptr_q[c] <= '0;
    end else if (state_q == ST_CLEAR) begin
      for (int c = 0; c < NUM_CH; c++) wptr_q[c] <= '0;
    end else if (wptr_adv) begin
      wptr_q[ch_q] <= (wptr_q[ch_q] == IDX_LAST) ? '0 : wptr_q[ch_q] + IDX_ONE;
    end
  end

  // Synchronous-read RAMs; contents are zeroed by the CLEAR sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (hist_we) hist_mem[hist_waddr] <= hist_wdat;
    if (coef_wen) coef_mem[coef_waddr] <= coef_wdat;
    hist_rd_q <= hist_mem[hist_raddr];
    coef_rd_q <= coef_mem[IDX_W'(cnt_q)];
  end

  fir_mac_core #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(acc_clr),
    .en_i (issue_vld_q),
    .x_i  (hist_rd_q),
    .h_i  (coef_rd_q),
    .y_o  (y),
    .sat_o(y_sat)
  );

endmodule
